// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin share of one overlapping serial
// pattern detector across NCH bit-stream channels.
module seq_det_arbiter #(
  parameter int              NCH       = 4,
  parameter int              PLEN      = 3,
  parameter logic [PLEN-1:0] PATTERN   = 3'b101,
  parameter int              MAX_BURST = 16,
  parameter int              CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH-1:0]          req_bit,
  input  logic [NCH-1:0]          req_last,
  output logic [NCH-1:0]          req_ready,
  output logic [NCH-1:0]          grant,
  output logic                    match_valid,
  output logic [$clog2(NCH)-1:0]  match_ch,
  input  logic                    clr_cnt,
  input  logic [$clog2(NCH)-1:0]  rd_ch,
  output logic [CNT_W-1:0]        rd_cnt
);

  localparam int CHW = $clog2(NCH);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } state_t;

  state_t          r_state;
  logic [CHW-1:0]  r_gidx;
  logic [CHW-1:0]  r_rr;
  logic [NCH-1:0]  r_grant;
  logic [NCH-1:0]  r_ready;
  logic [PLEN-1:0] r_hist;
  logic [BW-1:0]   r_bcnt;
  logic            r_mv;
  logic [CHW-1:0]  r_mch;
  logic [CNT_W-1:0] r_cnt [NCH];

  logic [CHW-1:0]  w_sel;
  logic [CHW-1:0]  w_k;
  logic [NCH-1:0]  w_sel_oh;
  logic            w_any;
  logic [PLEN-1:0] w_hist_nx;
  logic [BW-1:0]   w_bcnt_nx;
  logic            w_acc;
  logic            w_hit;
  logic            w_done;

  // first valid channel at or above rr_ptr, wrapping
  always_comb begin
    int k;
    k     = 0;
    w_k   = '0;
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(r_rr) + i;
      if (k >= NCH) k = k - NCH;
      w_k = CHW'(k);
      if (!w_any && req_valid[w_k]) begin
        w_any = 1'b1;
        w_sel = w_k;
      end
    end
    w_sel_oh        = '0;
    w_sel_oh[w_sel] = 1'b1;
  end

  assign w_acc     = (r_state == STREAM) && req_valid[r_gidx];
  assign w_hist_nx = {r_hist[PLEN-2:0], req_bit[r_gidx]};
  assign w_bcnt_nx = r_bcnt + 1'b1;
  assign w_hit     = w_acc && (w_hist_nx == PATTERN) &&
                     (w_bcnt_nx >= BW'(PLEN));
  assign w_done    = w_acc && (req_last[r_gidx] ||
                     (w_bcnt_nx == BW'(MAX_BURST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gidx  <= '0;
      r_rr    <= '0;
      r_grant <= '0;
      r_ready <= '0;
      r_hist  <= '0;
      r_bcnt  <= '0;
      r_mv    <= 1'b0;
      r_mch   <= '0;
    end else begin
      r_mv <= w_hit;
      if (w_hit) r_mch <= r_gidx;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= STREAM;
            r_gidx  <= w_sel;
            r_grant <= w_sel_oh;
            r_ready <= w_sel_oh;
            r_hist  <= '0;
            r_bcnt  <= '0;
          end
        end
        STREAM: begin
          if (w_acc) begin
            r_hist <= w_hist_nx;
            r_bcnt <= w_bcnt_nx;
            if (w_done) begin
              r_state <= GAP;
              r_grant <= '0;
              r_ready <= '0;
            end
          end
        end
        GAP: begin
          r_rr    <= (int'(r_gidx) == NCH - 1) ? '0 : r_gidx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // counters bump on the pulse cycle so a coincident clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (r_mv && (r_cnt[r_mch] != '1)) begin
      r_cnt[r_mch] <= r_cnt[r_mch] + 1'b1;
    end
  end

  assign req_ready   = r_ready;
  assign grant       = r_grant;
  assign match_valid = r_mv;
  assign match_ch    = r_mch;
  assign rd_cnt      = (int'(rd_ch) < NCH) ? r_cnt[rd_ch] : '0;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter: scoreboard bench, default DUT plus a
// CNT_W=2 copy driven in lockstep for saturation.
module tb_seq_det_arbiter;

  localparam int NCH  = 4;
  localparam int PLEN = 3;
  localparam int MAXB = 16;
  localparam int CW   = 8;
  localparam int CW2  = 2;
  localparam int PAT  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] req_valid = '0;
  logic [NCH-1:0] req_bit = '0;
  logic [NCH-1:0] req_last = '0;
  logic           clr_cnt = 1'b0;
  logic [1:0]     rd_ch = '0;

  logic [NCH-1:0] req_ready, req_ready2;
  logic [NCH-1:0] grant, grant2;
  logic           match_valid, match_valid2;
  logic [1:0]     match_ch, match_ch2;
  logic [CW-1:0]  rd_cnt;
  logic [CW2-1:0] rd_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int m_hist, m_n;
  int c8[NCH];
  int c2[NCH];

  always #5 clk = ~clk;

  seq_det_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_bit(req_bit),
    .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .match_valid(match_valid),
    .match_ch(match_ch), .clr_cnt(clr_cnt),
    .rd_ch(rd_ch), .rd_cnt(rd_cnt)
  );

  seq_det_arbiter #(.CNT_W(CW2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_bit(req_bit),
    .req_last(req_last), .req_ready(req_ready2),
    .grant(grant2), .match_valid(match_valid2),
    .match_ch(match_ch2), .clr_cnt(clr_cnt),
    .rd_ch(rd_ch), .rd_cnt(rd_cnt2)
  );

  task automatic mon();
    int e;
    n_cmp++;
    if (match_valid2 !== match_valid || grant2 !== grant) begin
      n_err++;
      $display("FAIL lockstep mv=%b/%b grant=%b/%b",
               match_valid, match_valid2, grant, grant2);
    end
    if (match_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_match got ch=%0d need none",
                 match_ch);
      end else begin
        e = exp_q.pop_front();
        if (int'(match_ch) !== e || match_ch2 !== match_ch) begin
          n_err++;
          $display("FAIL match_ch got %0d/%0d need %0d",
                   match_ch, match_ch2, e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_bit   = '0;
    req_last  = '0;
    clr_cnt   = 1'b0;
    rd_ch     = '0;
    exp_q.delete();
    m_hist = 0;
    m_n    = 0;
    for (int i = 0; i < NCH; i++) begin
      c8[i] = 0;
      c2[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_bit(input int ch, input bit b,
                           input bit l, input bit c);
    int n;
    bit hit;
    req_valid[ch] = 1'b1;
    req_bit[ch]   = b;
    req_last[ch]  = l;
    n = 0;
    while (req_ready[ch] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout ch=%0d got ready=%b need 1",
               ch, req_ready);
      req_valid[ch] = 1'b0;
      return;
    end
    if (m_n == MAXB) begin
      m_hist = 0;
      m_n    = 0;
    end
    m_hist = ((m_hist << 1) | int'(b)) & 7;
    m_n++;
    hit = (m_n >= PLEN) && (m_hist == PAT);
    if (hit) begin
      exp_q.push_back(ch);
      if (c) begin
        for (int i = 0; i < NCH; i++) begin
          c8[i] = 0;
          c2[i] = 0;
        end
      end else begin
        if (c8[ch] < 255) c8[ch]++;
        if (c2[ch] < 3) c2[ch]++;
      end
    end
    tick();
    n_cmp++;
    if (match_valid !== hit) begin
      n_err++;
      $display("FAIL match_pulse ch=%0d bit#%0d got %b need %b",
               ch, m_n, match_valid, hit);
    end
    if (l) begin
      req_valid[ch] = 1'b0;
      req_last[ch]  = 1'b0;
    end
    if (c) begin
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
    end
  endtask

  task automatic check_cnt(input int ch);
    rd_ch = 2'(ch);
    #1;
    n_cmp++;
    if (rd_cnt !== CW'(c8[ch])) begin
      n_err++;
      $display("FAIL cnt8 ch=%0d got %0d need %0d", ch, rd_cnt, c8[ch]);
    end
    n_cmp++;
    if (rd_cnt2 !== CW2'(c2[ch])) begin
      n_err++;
      $display("FAIL cnt2 ch=%0d got %0d need %0d", ch, rd_cnt2, c2[ch]);
    end
  endtask

  task automatic check_q_empty(input string nm);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing_matches got %0d pending need 0",
               nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (grant !== '0 || req_ready !== '0 ||
        match_valid !== 1'b0 || match_ch !== '0) begin
      n_err++;
      $display("FAIL reset_out got g=%b r=%b mv=%b mc=%0d need 0",
               grant, req_ready, match_valid, match_ch);
    end
    for (int i = 0; i < NCH; i++) check_cnt(i);
  endtask

  task automatic test_basic();
    bit [4:0] bits;
    do_reset();
    bits = 5'b10101;
    for (int i = 0; i < 5; i++)
      drive_bit(0, bits[4-i], i == 4, 1'b0);
    repeat (3) tick();
    check_q_empty("basic");
    check_cnt(0);
  endtask

  task automatic test_rr();
    logic [3:0] tbl [7];
    logic [3:0] acc;
    tbl = '{4'b0001, 4'b0000, 4'b0000, 4'b0100,
            4'b0000, 4'b0000, 4'b0000};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b0101;
      req_last  = 4'b0101;
      req_bit   = '0;
      for (int i = 0; i < 7; i++) begin
        acc = req_valid & req_ready;
        tick();
        req_valid = req_valid & ~acc;
        n_cmp++;
        if (grant !== tbl[i]) begin
          n_err++;
          $display("FAIL rr r=%0d cyc=%0d got %b need %b",
                   r, i, grant, tbl[i]);
        end
      end
    end
    req_last = '0;
  endtask

  task automatic test_max_burst();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_bit(1, (i % 2) == 0, 1'b0, 1'b0);
      if (i == MAXB - 1) begin
        n_cmp++;
        if (grant !== '0) begin
          n_err++;
          $display("FAIL forced_release got %b need 0000", grant);
        end
      end
    end
    req_valid[1] = 1'b0;
    repeat (3) tick();
    check_q_empty("max_burst");
    check_cnt(1);
  endtask

  task automatic test_no_carry();
    do_reset();
    drive_bit(0, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 1'b1, 1'b0);
    m_hist = 0;
    m_n    = 0;
    drive_bit(1, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check_q_empty("no_carry");
    check_cnt(0);
    check_cnt(1);
  endtask

  task automatic test_saturate_clear();
    bit [6:0] bits;
    do_reset();
    bits = 7'b1010101;
    for (int i = 0; i < 7; i++)
      drive_bit(3, bits[6-i], 1'b0, 1'b0);
    req_valid[3] = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_err++;
      $display("FAIL hold_grant got %b need 1000", grant);
    end
    check_cnt(3);
    drive_bit(3, 1'b0, 1'b0, 1'b0);
    drive_bit(3, 1'b1, 1'b0, 1'b0);
    req_valid[3] = 1'b0;
    repeat (3) tick();
    check_cnt(3);
    drive_bit(3, 1'b0, 1'b0, 1'b0);
    drive_bit(3, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    check_q_empty("sat_clr");
    check_cnt(3);
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive_bit(0, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 1'b0, 1'b0);
    rst       = 1'b1;
    req_valid = '0;
    #1;
    n_cmp++;
    if (grant !== '0 || req_ready !== '0 || match_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got g=%b r=%b mv=%b need 0",
               grant, req_ready, match_valid);
    end
    do_reset();
    drive_bit(0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check_q_empty("mid_reset");
    check_cnt(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_max_burst();
    test_no_carry();
    test_saturate_clear();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
Shares one overlapping serial pattern detector among NCH bit-stream requesters.
- A round-robin FSM grants one channel at a time for a burst of bits.
- The granted channel streams bits through the detector under a valid/ready handshake.
- Each match is reported with its channel ID, and a saturating match counter is kept per channel.
- The block sits between the serial front-end channels and the status/interrupt logic.

Parameters:
NCH, 4, number of requesting channels (2..8)
PLEN, 3, pattern length in bits (2..8)
PATTERN, 3'b101, pattern to detect; MSB is the oldest bit received
MAX_BURST, 16, maximum bits accepted per grant before forced release (>= PLEN)
CNT_W, 8, width of each per-channel match counter

Ports:
clk  input  1  clock
rst  input  1  reset: asynchronous, active-high
req_valid  input  NCH  per-channel bit valid
req_bit  input  NCH  per-channel serial data bit
req_last  input  NCH  marks the final bit of the channel's burst
req_ready  output  NCH  per-channel accept; a bit transfers when valid&ready
grant  output  NCH  one-hot current owner; all zero when idle
match_valid  output  1  one-cycle pulse: pattern detected
match_ch  output  $clog2(NCH)  channel that produced the match
clr_cnt  input  1  synchronous clear of all match counters
rd_ch  input  $clog2(NCH)  counter read select
rd_cnt  output  CNT_W  combinational read of counter[rd_ch]

Behaviour:
- Reset, asynchronous: state=IDLE, grant=0, req_ready=0, match_valid=0, match_ch=0, rr_ptr=0, history=0, burst count=0, all counters=0.
- FSM states and transitions:
  - IDLE: if any req_valid, pick the first valid channel searching from rr_ptr upward with wrap. Register grant, clear history and the burst count, go to STREAM. If no req_valid, stay in IDLE.
  - STREAM: req_ready[g]=1 only for the granted channel g; all other ready bits are 0. Each accepted bit shifts into history (LSB = newest) and increments the burst count.
    - Exit to GAP when the accepted bit has req_last=1 or the burst count reaches MAX_BURST.
    - If req_valid[g] is low, stay in STREAM without accepting a bit.
  - GAP: one cycle. grant=0, req_ready=0, rr_ptr=(g+1) mod NCH. Then go to IDLE.
- Handshake latency:
  - req_valid seen in IDLE at cycle N gives grant and req_ready high at cycle N+1.
  - Minimum idle between bursts is 2 cycles (GAP + IDLE).
- Detection:
  - A match occurs when an accepted bit makes the low PLEN bits of history equal PATTERN and at least PLEN bits have been accepted in this grant.
  - Detection is overlapping: history is not cleared on a match.
  - match_valid pulses on the cycle after the accepting edge, with match_ch=g.
  - History is cleared at every grant, so bits never carry across grants or channels, including a forced MAX_BURST release.
- Counters:
  - counter[g] increments on each match and saturates at 2^CNT_W-1.
  - clr_cnt zeroes all counters. If clr_cnt and an increment coincide, the clear wins and that match is not counted; match_valid still pulses.
- The last bit of a burst, or the MAX_BURST-th bit, is still eligible to match.
- req_valid of the granted channel dropping mid-burst does not release the grant; the burst waits for req_last or MAX_BURST.
- Reset asserted mid-burst returns everything to reset values immediately. A match pending in the pipeline is discarded.

Test Plan:
1. ch0 sends 1,0,1,0,1 (last on the 5th bit), defaults -> match_valid pulses after bits 3 and 5 with match_ch=0; rd_ch=0 gives rd_cnt=2.
2. ch0 and ch2 both valid from reset -> ch0 granted first, then 2-cycle gap, then ch2. Next, with ch0 and ch2 valid again -> ch2 is skipped until rr_ptr reaches it, so ch0 is granted before ch2.
3. ch1 sends 20 bits of repeating 10 with no last -> grant released after 16 bits; ch1 is re-granted when alone; the bit spanning the release does not complete a match; total count = 7+1 = 8 (history restarts at the regrant).
4. ch0 sends 1,0 (last), then ch1 sends 1 -> no match_valid pulse; both counters stay 0.
5. CNT_W=2, ch3 sends 1010101 -> 3 matches reach count 3; a further 4th match keeps the count at 3. clr_cnt asserted on a match cycle -> count 0, match_valid still pulses.
6. rst asserted during STREAM after bits 1,0 -> grant=0 and match_valid=0 immediately. After release, 1 alone gives no match (history was cleared).
